rr_arbiter_request_agent_2: RTL and testbench

- Requester-side companion to the 2-request round-robin arbiter. Buffers transactions from two upstream clients in per-client FIFOs and drives the arbiter's `requests` bus from FIFO occupancy.
- Consumes the arbiter's `grants` bus, pops the granted client's head entry and forwards it on a single merged output stream tagged with the client id.
- Checks that the grant protocol is legal.

---
 rtl/rr_arbiter_request_agent_2.sv | 133 +++++++++++++
 tb/tb_rr_arbiter_request_agent_2.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_request_agent_2.sv
// Two-client request agent for a 2-way round-robin arbiter: per-client FIFOs drive requests, grants pop onto one tagged stream.
// Latency: input to output is one cycle at minimum, with no bypass. Backpressure: in_ready drops at full, and a grant is always consumed.

module rr_arbiter_request_agent_2_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[wptr_q] = push_data;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rptr_q];
    assign count = count_q;
endmodule

module rr_arbiter_request_agent_2 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     in_valid,
    input  logic [2*DATA_W-1:0]            in_data,
    output logic [1:0]                     in_ready,
    output logic [1:0]                     requests,
    input  logic [1:0]                     grants,
    output logic                           out_valid,
    output logic                           out_id,
    output logic [DATA_W-1:0]              out_data,
    output logic [2*($clog2(DEPTH)+1)-1:0] level,
    output logic                           protocol_error
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]     count [2];
    logic [DATA_W-1:0] head  [2];
    logic [1:0]        push;
    logic [1:0]        pop;
    logic              gnt_legal;
    logic              gnt_illegal;
    logic              protocol_error_q, protocol_error_d;

    for (genvar i = 0; i < 2; i++) begin : g_client
        rr_arbiter_request_agent_2_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .push_data (in_data[i*DATA_W +: DATA_W]),
            .pop       (pop[i]),
            .head      (head[i]),
            .count     (count[i])
        );

        // Requests come only from registered occupancy, so there is no loop through the arbiter.
        assign in_ready[i]          = (count[i] != CW'(DEPTH));
        assign requests[i]          = (count[i] != '0);
        assign push[i]              = in_valid[i] & in_ready[i];
        assign level[i*CW +: CW]    = count[i];
    end

    always_comb begin
        gnt_legal        = ((grants == 2'b01) && requests[0]) ||
                           ((grants == 2'b10) && requests[1]);
        gnt_illegal      = (grants != 2'b00) && !gnt_legal;
        pop              = gnt_legal ? grants : 2'b00;
        out_valid        = gnt_legal;
        out_id           = gnt_legal & grants[1];
        out_data         = gnt_legal ? head[grants[1]] : '0;
        protocol_error_d = protocol_error_q | gnt_illegal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            protocol_error_q <= 1'b0;
        end else begin
            protocol_error_q <= protocol_error_d;
        end
    end

    assign protocol_error = protocol_error_q;
endmodule

// File: tb/tb_rr_arbiter_request_agent_2.sv
// Bench for rr_arbiter_request_agent_2: a round-robin arbiter model closes the loop, and a per-client scoreboard predicts every cycle.
module tb_rr_arbiter_request_agent_2;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        in_valid = 2'b00;
    logic [2*DATA_W-1:0] in_data = '0;
    logic [1:0]        in_ready;
    logic [1:0]        requests;
    logic [1:0]        grants;
    logic              out_valid;
    logic              out_id;
    logic [DATA_W-1:0] out_data;
    logic [2*CW-1:0]   level;
    logic              protocol_error;

    logic       arb_en    = 1'b0;
    logic       force_en  = 1'b0;
    logic [1:0] force_val = 2'b00;
    logic       prio;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] out_log[$];
    logic [DATA_W-1:0] exp_log[$];
    logic              model_err = 1'b0;

    rr_arbiter_request_agent_2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .requests       (requests),
        .grants         (grants),
        .out_valid      (out_valid),
        .out_id         (out_id),
        .out_data       (out_data),
        .level          (level),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    // Fair 2-way arbiter; prio = 1 means client 1 wins a tie.
    always_comb begin
        grants = 2'b00;
        if (force_en) begin
            grants = force_val;
        end else if (arb_en) begin
            if (requests == 2'b11) grants = prio ? 2'b10 : 2'b01;
            else                   grants = requests;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (grants == 2'b01 && requests[0]) begin
            prio <= 1'b1;
        end else if (grants == 2'b10 && requests[1]) begin
            prio <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the state the DUT shows now, then advance the model to the coming edge.
    always @(negedge clk) begin
        if (!rst) begin
            int s0;
            int s1;
            logic legal;
            logic [DATA_W-1:0] e;
            s0 = q0.size();
            s1 = q1.size();
            chk("level0", 32'(level[CW-1:0]), 32'(s0));
            chk("level1", 32'(level[2*CW-1:CW]), 32'(s1));
            chk("in_ready", 32'(in_ready), {30'd0, s1 != DEPTH, s0 != DEPTH});
            chk("requests", 32'(requests), {30'd0, s1 != 0, s0 != 0});
            chk("perr", 32'(protocol_error), 32'(model_err));
            legal = (grants == 2'b01 && s0 != 0) || (grants == 2'b10 && s1 != 0);
            chk("out_valid", 32'(out_valid), 32'(legal));
            if (legal) begin
                e = grants[1] ? q1.pop_front() : q0.pop_front();
                chk("out_id", 32'(out_id), 32'(grants[1]));
                chk("out_data", 32'(out_data), 32'(e));
                out_log.push_back(out_data);
            end else begin
                chk("idle_id", 32'(out_id), 32'd0);
                chk("idle_data", 32'(out_data), 32'd0);
            end
            if (grants != 2'b00 && !legal) model_err = 1'b1;
            if (in_valid[0] && s0 != DEPTH) q0.push_back(in_data[DATA_W-1:0]);
            if (in_valid[1] && s1 != DEPTH) q1.push_back(in_data[2*DATA_W-1:DATA_W]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 2'b00;
        arb_en    = 1'b0;
        force_en  = 1'b0;
        q0.delete();
        q1.delete();
        out_log.delete();
        model_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(q0.size() + q1.size()), 32'd0);
        tick();
    endtask

    task automatic compare_log(input string tag);
        chk(tag, 32'(out_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < out_log.size(); i++) begin
            chk(tag, 32'(out_log[i]), 32'(exp_log[i]));
        end
        out_log.delete();
        exp_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        arb_en = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_requests", 32'(requests), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd3);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_perr", 32'(protocol_error), 32'd0);

        // Latency: A5 pushed in cycle 0 appears in cycle 1.
        tick();
        in_valid = 2'b01;
        in_data  = 16'h00A5;
        tick();
        in_valid = 2'b00;
        @(negedge clk);
        chk("lat_requests", 32'(requests), 32'd1);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_id", 32'(out_id), 32'd0);
        chk("lat_data", 32'(out_data), 32'hA5);
        tick();
        @(negedge clk);
        chk("lat_level0", 32'(level[CW-1:0]), 32'd0);
        tick();

        // Contention: strict alternation, client 0 first after reset.
        do_reset();
        in_valid = 2'b11; in_data = 16'h2010; tick();
        in_valid = 2'b11; in_data = 16'h2111; tick();
        in_valid = 2'b00;
        arb_en   = 1'b1;
        drain();
        exp_log = '{8'h10, 8'h20, 8'h11, 8'h21};
        compare_log("contend_order");

        // Full boundary: the fifth word is refused.
        arb_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 2'b01;
            in_data  = 16'(8'h30 + k);
            tick();
        end
        in_valid = 2'b00;
        @(negedge clk);
        chk("full_level0", 32'(level[CW-1:0]), 32'd4);
        chk("full_ready0", 32'(in_ready[0]), 32'd0);
        tick();
        arb_en = 1'b1;
        drain();
        exp_log = '{8'h30, 8'h31, 8'h32, 8'h33};
        compare_log("full_drain");

        // Push and pop together at level 2 across pointer wrap.
        arb_en = 1'b0;
        in_valid = 2'b10; in_data = 16'h4000; tick();
        in_valid = 2'b10; in_data = 16'h4100; tick();
        arb_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 2'b10;
            in_data  = {8'(8'h42 + k), 8'h00};
            @(negedge clk);
            chk("pp_level1", 32'(level[2*CW-1:CW]), 32'd2);
            tick();
        end
        in_valid = 2'b00;
        drain();
        for (int k = 0; k < 12; k++) exp_log.push_back(8'(8'h40 + k));
        compare_log("pp_order");

        // Illegal grant 11: no pop, error set, pushes unaffected.
        do_reset();
        in_valid = 2'b01; in_data = 16'h0055; tick();
        force_en = 1'b1; force_val = 2'b11;
        in_valid = 2'b10; in_data = 16'h6600;
        @(negedge clk);
        chk("g11_valid", 32'(out_valid), 32'd0);
        tick();
        force_en = 1'b0;
        in_valid = 2'b00;
        @(negedge clk);
        chk("g11_perr", 32'(protocol_error), 32'd1);
        chk("g11_level0", 32'(level[CW-1:0]), 32'd1);
        chk("g11_level1", 32'(level[2*CW-1:CW]), 32'd1);
        tick();

        // Grant to an empty client.
        do_reset();
        force_en = 1'b1; force_val = 2'b10;
        tick();
        force_en = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("g10_perr", 32'(protocol_error), 32'd1);
        tick();

        // Reset in the middle of a stream clears everything at once.
        arb_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 2'b11;
            in_data  = {8'(8'h70 + k), 8'(8'h80 + k)};
            tick();
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_perr", 32'(protocol_error), 32'd0);
        chk("mid_level", 32'(level), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_data", 32'(out_data), 32'd0);
        chk("mid_ready", 32'(in_ready), 32'd3);
        in_valid = 2'b00;
        q0.delete();
        q1.delete();
        model_err = 1'b0;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("post_valid", 32'(out_valid), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
